// File: rtl/isdu_param.sv
// isdu_param: LC-3 style instruction sequencer/decoder control unit.
// Each SRAM access is a single state held for MEM_WAIT cycles.
// Optional build macro: ISDU_PAUSE_EN adds PAUSE1/PAUSE2 and LD_LED.
//
// state  | meaning
// HALTED | idle after reset, waits for Run
// F18    | MAR <= PC, PC <= PC+1
// RD33   | instruction fetch read
// IR35   | IR <= MDR
// DEC32  | BEN latch, opcode dispatch
// ADD1   | ADD
// AND5   | AND
// NOT9   | NOT
// BR0    | branch test on BEN
// BR22   | PC <= PC+off9
// JMP12  | PC <= BaseR
// JSR4   | R7 <= PC
// JSR21  | PC <= PC+off11
// JSRR20 | PC <= BaseR
// LEA14  | DR <= PC+off9
// LD2    | MAR <= PC+off9 (LD)
// RD25   | data read (LD/LDI)
// LD27   | DR <= MDR
// LDI10  | MAR <= PC+off9 (LDI)
// RD24   | pointer read (LDI)
// LDI26  | MAR <= MDR (LDI)
// ST3    | MAR <= PC+off9 (ST)
// STI11  | MAR <= PC+off9 (STI)
// RD29   | pointer read (STI)
// STI31  | MAR <= MDR (STI)
// ST23   | MDR <= SR
// WR16   | data write
// PAUSE1 | LD_LED, wait for Continue=1
// PAUSE2 | wait for Continue=0
module isdu_param #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, F18, RD33, IR35, DEC32, ADD1, AND5, NOT9, BR0, BR22,
        JMP12, JSR4, JSR21, JSRR20, LEA14, LD2, RD25, LD27, LDI10, RD24,
        LDI26, ST3, STI11, RD29, STI31, ST23, WR16
`ifdef ISDU_PAUSE_EN
        , PAUSE1, PAUSE2
`endif
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t     state, next_state;
    logic [3:0] wait_cnt;
    logic       next_is_mem;

    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

    // State register and memory wait counter (loaded only when entering an access)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (state != next_state && next_is_mem)
                wait_cnt <= WAIT_INIT;
            else if (wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Next-state and control-word decode
    always_comb begin
        next_state = state;
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        case (state)
            HALTED: if (Run) next_state = F18;
            F18: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
                next_state = RD33;
            end
            RD33, RD25, RD24, RD29: begin
                Mem_OE = 1'b0;
                if (wait_cnt == 4'd0) begin
                    LD_MDR = 1'b1;
                    case (state)
                        RD33:    next_state = IR35;
                        RD25:    next_state = LD27;
                        RD24:    next_state = LDI26;
                        default: next_state = STI31;
                    endcase
                end
            end
            IR35: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
                next_state = DEC32;
            end
            DEC32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: next_state = ADD1;
                    4'b0101: next_state = AND5;
                    4'b1001: next_state = NOT9;
                    4'b0000: next_state = BR0;
                    4'b1100: next_state = JMP12;
                    4'b0100: next_state = JSR4;
                    4'b1110: next_state = LEA14;
                    4'b0010: next_state = LD2;
                    4'b1010: next_state = LDI10;
                    4'b0011: next_state = ST3;
                    4'b1011: next_state = STI11;
`ifdef ISDU_PAUSE_EN
                    4'b1101: next_state = PAUSE1;
`endif
                    default: next_state = F18;
                endcase
            end
            ADD1, AND5, NOT9: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                DRMUX = 1'b1; SR1MUX = 1'b1; SR2MUX = IR_5;
                ALUK = (state == ADD1) ? 2'b00 : (state == AND5) ? 2'b01 : 2'b10;
                next_state = F18;
            end
            BR0: next_state = BEN ? BR22 : F18;
            BR22: begin
                LD_PC = 1'b1; PCMUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
                next_state = F18;
            end
            JMP12: begin
                LD_PC = 1'b1; PCMUX = 2'b01; SR1MUX = 1'b1; ADDR2MUX = 2'b11;
                next_state = F18;
            end
            JSR4: begin
                GatePC = 1'b1; LD_REG = 1'b1; DRMUX = 1'b0;
                next_state = IR_11 ? JSR21 : JSRR20;
            end
            JSR21: begin
                LD_PC = 1'b1; PCMUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b10;
                next_state = F18;
            end
            // base register field is the same one JMP uses
            JSRR20: begin
                LD_PC = 1'b1; PCMUX = 2'b01; SR1MUX = 1'b1; ADDR2MUX = 2'b11;
                next_state = F18;
            end
            LEA14: begin
                GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; DRMUX = 1'b1;
                next_state = F18;
            end
            LD2, LDI10, ST3, STI11: begin
                GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
                case (state)
                    LD2:     next_state = RD25;
                    LDI10:   next_state = RD24;
                    ST3:     next_state = ST23;
                    default: next_state = RD29;
                endcase
            end
            LD27: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; DRMUX = 1'b1;
                next_state = F18;
            end
            LDI26, STI31: begin
                GateMDR = 1'b1; LD_MAR = 1'b1;
                next_state = (state == LDI26) ? RD25 : ST23;
            end
            ST23: begin
                GateALU = 1'b1; ALUK = 2'b11; LD_MDR = 1'b1;
                next_state = WR16;
            end
            WR16: begin
                Mem_WE = 1'b0;
                if (wait_cnt == 4'd0) next_state = F18;
            end
`ifdef ISDU_PAUSE_EN
            PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) next_state = PAUSE2;
            end
            PAUSE2: if (!Continue) next_state = F18;
`endif
            default: next_state = F18;
        endcase
        next_is_mem = (next_state == RD33) || (next_state == RD25) || (next_state == RD24) ||
                      (next_state == RD29) || (next_state == WR16);
    end

`ifndef ISDU_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

endmodule

// File: tb/tb_isdu_param.sv
// Testbench for isdu_param: four instances (MEM_WAIT 2..5) share stimulus and
// are compared cycle by cycle against per-instruction control-word traces.
module tb_isdu_param;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue;
    logic [3:0] Opcode;
    logic       IR_5, IR_11, BEN;

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
    } ctl_t;

    typedef ctl_t ctl_q_t[$];

    typedef enum {
        T_IDLE, T_F18, T_RD, T_WR, T_IR35, T_DEC, T_ADD, T_AND, T_NOT, T_BR22,
        T_JMP, T_JSR4, T_JSR21, T_JSRR20, T_LEA, T_MARPC, T_LD27, T_MDR2MAR,
        T_ST23, T_PAUSE1
    } step_e;

    ctl_t obs [4];
    int   checks   = 0;
    int   failures = 0;
    int   cnt_oe [4];
    int   cnt_we [4];
    int   cnt_both [4];
    int   cnt_ldreg [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
        logic GatePC, GateMDR, GateALU, GateMARMUX;
        logic [1:0] PCMUX, ADDR2MUX, ALUK;
        logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
        logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

        isdu_param #(.MEM_WAIT(g + 2)) u_dut (
            .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
            .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
            .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
            .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
            .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
            .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
            .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
            .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
        );

        assign obs[g] = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                         GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                         DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                         Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Control word of one abstract micro-step
    function automatic ctl_t step_ctl(step_e s, logic ir5, logic last);
        ctl_t v;
        v = '0;
        v.mem_oe = 1'b1;
        v.mem_we = 1'b1;
        case (s)
            T_F18:   begin v.gate_pc = 1'b1; v.ld_mar = 1'b1; v.ld_pc = 1'b1; end
            T_RD:    begin v.mem_oe = 1'b0; v.ld_mdr = last; end
            T_WR:    v.mem_we = 1'b0;
            T_IR35:  begin v.gate_mdr = 1'b1; v.ld_ir = 1'b1; end
            T_DEC:   v.ld_ben = 1'b1;
            T_ADD, T_AND, T_NOT: begin
                v.gate_alu = 1'b1; v.ld_reg = 1'b1; v.ld_cc = 1'b1;
                v.drmux = 1'b1; v.sr1mux = 1'b1; v.sr2mux = ir5;
                v.aluk = (s == T_ADD) ? 2'd0 : (s == T_AND) ? 2'd1 : 2'd2;
            end
            T_BR22:  begin v.ld_pc = 1'b1; v.pcmux = 2'b01; v.addr1mux = 1'b1; v.addr2mux = 2'b01; end
            T_JMP:   begin v.ld_pc = 1'b1; v.pcmux = 2'b01; v.sr1mux = 1'b1; v.addr2mux = 2'b11; end
            T_JSR4:  begin v.gate_pc = 1'b1; v.ld_reg = 1'b1; end
            T_JSR21: begin v.ld_pc = 1'b1; v.pcmux = 2'b01; v.addr1mux = 1'b1; v.addr2mux = 2'b10; end
            T_JSRR20: begin v.ld_pc = 1'b1; v.pcmux = 2'b01; v.sr1mux = 1'b1; v.addr2mux = 2'b11; end
            T_LEA:   begin
                v.gate_marmux = 1'b1; v.ld_reg = 1'b1; v.ld_cc = 1'b1;
                v.addr1mux = 1'b1; v.addr2mux = 2'b01; v.drmux = 1'b1;
            end
            T_MARPC: begin v.gate_marmux = 1'b1; v.ld_mar = 1'b1; v.addr1mux = 1'b1; v.addr2mux = 2'b01; end
            T_LD27:  begin v.gate_mdr = 1'b1; v.ld_reg = 1'b1; v.ld_cc = 1'b1; v.drmux = 1'b1; end
            T_MDR2MAR: begin v.gate_mdr = 1'b1; v.ld_mar = 1'b1; end
            T_ST23:  begin v.gate_alu = 1'b1; v.aluk = 2'b11; v.ld_mdr = 1'b1; end
            T_PAUSE1: v.ld_led = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    // Expected trace from HALTED: the same instruction executed repeatedly
    function automatic ctl_q_t build_trace(logic [3:0] op, logic ben, logic ir5, logic ir11,
                                           int w, int len);
        ctl_q_t q;
        q.push_back(step_ctl(T_IDLE, ir5, 1'b0));
        while (q.size() < len) begin
            q.push_back(step_ctl(T_F18, ir5, 1'b0));
            for (int i = 0; i < w; i++) q.push_back(step_ctl(T_RD, ir5, i == w - 1));
            q.push_back(step_ctl(T_IR35, ir5, 1'b0));
            q.push_back(step_ctl(T_DEC, ir5, 1'b0));
            case (op)
                4'b0001: q.push_back(step_ctl(T_ADD, ir5, 1'b0));
                4'b0101: q.push_back(step_ctl(T_AND, ir5, 1'b0));
                4'b1001: q.push_back(step_ctl(T_NOT, ir5, 1'b0));
                4'b0000: begin
                    q.push_back(step_ctl(T_IDLE, ir5, 1'b0));
                    if (ben) q.push_back(step_ctl(T_BR22, ir5, 1'b0));
                end
                4'b1100: q.push_back(step_ctl(T_JMP, ir5, 1'b0));
                4'b0100: begin
                    q.push_back(step_ctl(T_JSR4, ir5, 1'b0));
                    q.push_back(step_ctl(ir11 ? T_JSR21 : T_JSRR20, ir5, 1'b0));
                end
                4'b1110: q.push_back(step_ctl(T_LEA, ir5, 1'b0));
                4'b0010: begin
                    q.push_back(step_ctl(T_MARPC, ir5, 1'b0));
                    for (int i = 0; i < w; i++) q.push_back(step_ctl(T_RD, ir5, i == w - 1));
                    q.push_back(step_ctl(T_LD27, ir5, 1'b0));
                end
                4'b1010: begin
                    q.push_back(step_ctl(T_MARPC, ir5, 1'b0));
                    for (int i = 0; i < w; i++) q.push_back(step_ctl(T_RD, ir5, i == w - 1));
                    q.push_back(step_ctl(T_MDR2MAR, ir5, 1'b0));
                    for (int i = 0; i < w; i++) q.push_back(step_ctl(T_RD, ir5, i == w - 1));
                    q.push_back(step_ctl(T_LD27, ir5, 1'b0));
                end
                4'b0011: begin
                    q.push_back(step_ctl(T_MARPC, ir5, 1'b0));
                    q.push_back(step_ctl(T_ST23, ir5, 1'b0));
                    for (int i = 0; i < w; i++) q.push_back(step_ctl(T_WR, ir5, 1'b0));
                end
                4'b1011: begin
                    q.push_back(step_ctl(T_MARPC, ir5, 1'b0));
                    for (int i = 0; i < w; i++) q.push_back(step_ctl(T_RD, ir5, i == w - 1));
                    q.push_back(step_ctl(T_MDR2MAR, ir5, 1'b0));
                    q.push_back(step_ctl(T_ST23, ir5, 1'b0));
                    for (int i = 0; i < w; i++) q.push_back(step_ctl(T_WR, ir5, 1'b0));
                end
`ifdef ISDU_PAUSE_EN
                4'b1101: for (int i = 0; i < len; i++) q.push_back(step_ctl(T_PAUSE1, ir5, 1'b0));
`endif
                default: ;
            endcase
        end
        return q;
    endfunction

    // Reset, start with Run, compare len cycles; optional Reset pulse in cycle rst_at
    task automatic run_trace(input logic [3:0] op, input logic ben, input logic ir5,
                             input logic ir11, input int rst_at, input int len, input string name);
        ctl_q_t exp [4];
        Opcode = op; BEN = ben; IR_5 = ir5; IR_11 = ir11;
        Continue = 1'b0; Run = 1'b0; Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            exp[g] = build_trace(op, ben, ir5, ir11, g + 2, len);
            cnt_oe[g] = 0; cnt_we[g] = 0; cnt_both[g] = 0; cnt_ldreg[g] = 0;
        end
        for (int c = 0; c < len; c++) begin
            if (c > 0) begin
                @(posedge Clk);
                #1;
            end
            Reset = (c == rst_at);
            Run = (c == 0 || c == rst_at + 1) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int g = 0; g < 4; g++) begin
                int k;
                k = (rst_at >= 0 && c > rst_at) ? c - rst_at - 1 : c;
                check_eq($sformatf("%s w%0d c%0d", name, g + 2, c), 32'(obs[g]), 32'(exp[g][k]));
                if (!obs[g].mem_oe) cnt_oe[g]++;
                if (!obs[g].mem_we) cnt_we[g]++;
                if (!obs[g].mem_oe && !obs[g].mem_we) cnt_both[g]++;
                if (obs[g].ld_reg) cnt_ldreg[g]++;
            end
        end
        Reset = 1'b0;
        Run = 1'b0;
    endtask

    initial begin
        ctl_t idle_v, led_v, f18_v;
        idle_v = step_ctl(T_IDLE, 1'b0, 1'b0);
        led_v  = step_ctl(T_PAUSE1, 1'b0, 1'b0);
        f18_v  = step_ctl(T_F18, 1'b0, 1'b0);

        // HALTED holds while Run=0
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'b0001; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int g = 0; g < 4; g++)
                check_eq($sformatf("halted w%0d c%0d", g + 2, c), 32'(obs[g]), 32'(idle_v));
            @(posedge Clk);
            #1;
        end

        run_trace(4'b0001, 1'b0, 1'b0, 1'b0, -1, 24, "add_r");
        run_trace(4'b0001, 1'b0, 1'b1, 1'b0, -1, 24, "add_i");
        run_trace(4'b0101, 1'b1, 1'b1, 1'b0, -1, 24, "and");
        run_trace(4'b1001, 1'b0, 1'b0, 1'b1, -1, 24, "not");
        run_trace(4'b0000, 1'b0, 1'b0, 1'b0, -1, 30, "br_nt");
        run_trace(4'b0000, 1'b1, 1'b0, 1'b0, -1, 30, "br_t");
        run_trace(4'b1100, 1'b0, 1'b0, 1'b0, -1, 24, "jmp");
        run_trace(4'b0100, 1'b0, 1'b0, 1'b1, -1, 30, "jsr");
        run_trace(4'b0100, 1'b0, 1'b0, 1'b0, -1, 30, "jsrr");
        run_trace(4'b1110, 1'b0, 1'b0, 1'b0, -1, 24, "lea");
        run_trace(4'b0010, 1'b0, 1'b0, 1'b0, -1, 36, "ld");
        run_trace(4'b0011, 1'b0, 1'b0, 1'b0, -1, 36, "st");
        run_trace(4'b0110, 1'b0, 1'b0, 1'b0, -1, 24, "rsv6");
        run_trace(4'b1111, 1'b0, 1'b0, 1'b0, -1, 24, "trap");
        run_trace(4'b1101, 1'b0, 1'b0, 1'b0, -1, 24, "op1101");

        // One LDI instruction at MEM_WAIT=5: 1 + 8 fetch + 13 execute cycles
        run_trace(4'b1010, 1'b0, 1'b0, 1'b0, -1, 22, "ldi");
        check_eq("ldi_w5_oe_cycles", 32'(cnt_oe[3]), 32'd15);
        check_eq("ldi_w5_ld_reg", 32'(cnt_ldreg[3]), 32'd1);

        // One STI instruction at MEM_WAIT=3: 1 + 6 fetch + 9 execute cycles
        run_trace(4'b1011, 1'b0, 1'b0, 1'b0, -1, 16, "sti");
        check_eq("sti_w3_we_cycles", 32'(cnt_we[1]), 32'd3);
        check_eq("sti_w3_oe_during_we", 32'(cnt_both[1]), 32'd0);
        check_eq("sti_w3_oe_cycles", 32'(cnt_oe[1]), 32'd6);

        // Reset during cycle 2 of RD25 for MEM_WAIT=4 (RD25 spans cycles 9..12)
        run_trace(4'b0010, 1'b0, 1'b0, 1'b0, 10, 30, "ld_rst");

`ifdef ISDU_PAUSE_EN
        run_trace(4'b1101, 1'b0, 1'b0, 1'b0, -1, 20, "pause");
        @(posedge Clk);
        #1;
        for (int g = 0; g < 4; g++)
            check_eq($sformatf("pause_hold w%0d", g + 2), 32'(obs[g]), 32'(led_v));
        Continue = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clk);
            #1;
            for (int g = 0; g < 4; g++)
                check_eq($sformatf("pause2 w%0d c%0d", g + 2, c), 32'(obs[g]), 32'(idle_v));
        end
        Continue = 1'b0;
        @(posedge Clk);
        #1;
        for (int g = 0; g < 4; g++)
            check_eq($sformatf("pause_exit w%0d", g + 2), 32'(obs[g]), 32'(f18_v));
`else
        check_eq("led_idle", 32'(led_v.ld_led), 32'(g_dut[0].LD_LED) | 32'd1);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [3:0] op;
            int         ra;
            op = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(3, 35));
            run_trace(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ra, 45, $sformatf("rnd%0d_op%0h", t, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
